fetch_buffer: RTL and testbench

Parametrised instruction buffer that decouples instruction fetch from decode/issue in the superscalar front end. Each cycle it accepts one fetch group of `LANES` instructions with a base PC and a lane-valid mask, and compacts the valid lanes into a circular queue. It presents the oldest `LANES` entries to decode, and the issue stage retires 0..`LANES` of them per cycle. Its backpressure output replaces the fixed two-wide frontend write-enable, which enables partial issue, misaligned branch targets and pipeline flush.

---
 rtl/fetch_buffer_pkg.sv | 17 +
 rtl/fetch_compact.sv | 26 ++
 rtl/fetch_buffer.sv | 116 +++++++++++
 tb/tb_fetch_buffer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_buffer_pkg.sv
// rtl/fetch_buffer_pkg.sv - shared fetch-buffer sizing and entry field slices
`ifndef FETCH_BUFFER_PKG_SV
`define FETCH_BUFFER_PKG_SV

// An entry is {inst, pc}, each w bits wide
`define FB_INST(e, w) e[2*(w)-1 -: (w)]
`define FB_PC(e, w)   e[(w)-1:0]

package fetch_buffer_pkg;

    localparam int FB_LANES = 2;
    localparam int FB_DEPTH = 8;
    localparam int FB_XLEN  = 32;

endpackage

`endif

// File: rtl/fetch_compact.sv
// rtl/fetch_compact.sv - lane mask to compacted write offsets and popcount
module fetch_compact
    import fetch_buffer_pkg::*;
#(
    parameter int LANES = FB_LANES,
    parameter int NW    = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0]    mask_i,
    output logic [LANES*NW-1:0] offs_o,
    output logic [NW-1:0]       pop_o
);

    logic [NW-1:0] run;

    // Lane j sits at mask bit LANES-1-j; its offset is the count of valid older lanes
    always_comb begin
        run    = '0;
        offs_o = '0;
        for (int j = 0; j < LANES; j++) begin
            offs_o[j*NW +: NW] = run;
            run = run + NW'(mask_i[LANES-1-j]);
        end
        pop_o = run;
    end

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - compacting circular instruction buffer between fetch and decode
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int LANES = FB_LANES,
    parameter int DEPTH = FB_DEPTH,
    parameter int XLEN  = FB_XLEN,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                          clock_i,
    input  logic                          reset_n_i,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [LANES*XLEN-1:0]         in_data_i,
    input  logic [LANES-1:0]              in_mask_i,
    input  logic [XLEN-1:0]               in_pc_i,
    output logic [LANES-1:0]              out_valid_o,
    output logic [LANES*XLEN-1:0]         out_inst_o,
    output logic [LANES*XLEN-1:0]         out_pc_o,
    input  logic [$clog2(LANES+1)-1:0]    deq_cnt_i,
    output logic [CNT_W-1:0]              count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int NW    = $clog2(LANES + 1);
    localparam int EW    = 2 * XLEN;

    logic [EW-1:0]       entries_q [DEPTH];
    logic [EW-1:0]       entries_d [DEPTH];
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [LANES*NW-1:0] lane_off;
    logic [NW-1:0]       enq_n;
    logic                enq;
    logic [CNT_W-1:0]    deq_req, deq_eff, enq_eff;
    logic [PTR_W-1:0]    wr_idx, rd_idx;

    fetch_compact #(
        .LANES (LANES),
        .NW    (NW)
    ) u_compact (
        .mask_i (in_mask_i),
        .offs_o (lane_off),
        .pop_o  (enq_n)
    );

    assign in_ready_o = (count_q <= CNT_W'(DEPTH - LANES));
    assign count_o    = count_q;

    always_comb begin
        enq       = in_valid_i & in_ready_o & ~flush_i;
        deq_req   = CNT_W'(deq_cnt_i);
        deq_eff   = (deq_req < count_q) ? deq_req : count_q;
        enq_eff   = enq ? CNT_W'(enq_n) : '0;
        entries_d = entries_q;
        wr_idx    = '0;
        for (int j = 0; j < LANES; j++) begin
            wr_idx = tail_q + PTR_W'(lane_off[j*NW +: NW]);
            if (enq && in_mask_i[LANES-1-j]) begin
                entries_d[wr_idx] = {in_data_i[(LANES-1-j)*XLEN +: XLEN],
                                     in_pc_i + XLEN'(4 * j)};
            end
        end
        // DEPTH is a power of two, so truncating the add wraps the pointers
        head_d  = head_q + PTR_W'(deq_eff);
        tail_d  = tail_q + PTR_W'(enq_eff);
        count_d = count_q + enq_eff - deq_eff;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Invalid slots read as zero so they never carry stale or X data
    always_comb begin
        out_valid_o = '0;
        out_inst_o  = '0;
        out_pc_o    = '0;
        rd_idx      = '0;
        for (int k = 0; k < LANES; k++) begin
            rd_idx         = head_q + PTR_W'(k);
            out_valid_o[k] = (count_q > CNT_W'(k));
            if (out_valid_o[k]) begin
                out_inst_o[(LANES-1-k)*XLEN +: XLEN] = `FB_INST(entries_q[rd_idx], XLEN);
                out_pc_o[(LANES-1-k)*XLEN +: XLEN]   = `FB_PC(entries_q[rd_idx], XLEN);
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            entries_q <= entries_d;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - scoreboard bench for fetch_buffer
module tb_fetch_buffer;

    localparam int LANES = 2;
    localparam int DEPTH = 8;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic                  clock_i;
    logic                  reset_n_i;
    logic                  flush_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [LANES*XLEN-1:0] in_data_i;
    logic [LANES-1:0]      in_mask_i;
    logic [XLEN-1:0]       in_pc_i;
    logic [LANES-1:0]      out_valid_o;
    logic [LANES*XLEN-1:0] out_inst_o;
    logic [LANES*XLEN-1:0] out_pc_o;
    logic [1:0]            deq_cnt_i;
    logic [CNT_W-1:0]      count_o;

    fetch_buffer #(
        .LANES (LANES),
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) dut (
        .clock_i     (clock_i),
        .reset_n_i   (reset_n_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_mask_i   (in_mask_i),
        .in_pc_i     (in_pc_i),
        .out_valid_o (out_valid_o),
        .out_inst_o  (out_inst_o),
        .out_pc_o    (out_pc_o),
        .deq_cnt_i   (deq_cnt_i),
        .count_o     (count_o)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag);
        logic [1:0] ev;
        int         n;
        n = sb.size();
        ev[0] = (n > 0);
        ev[1] = (n > 1);
        check({tag, ".count"}, 64'(count_o), 64'(n));
        check({tag, ".ready"}, 64'(in_ready_o), 64'((DEPTH - n) >= LANES));
        check({tag, ".valid"}, 64'(out_valid_o), 64'(ev));
        if (n > 0) begin
            check({tag, ".inst0"}, 64'(out_inst_o[63:32]), 64'(sb[0].inst));
            check({tag, ".pc0"},   64'(out_pc_o[63:32]),   64'(sb[0].pc));
        end
        if (n > 1) begin
            check({tag, ".inst1"}, 64'(out_inst_o[31:0]), 64'(sb[1].inst));
            check({tag, ".pc1"},   64'(out_pc_o[31:0]),   64'(sb[1].pc));
        end
    endtask

    // Drive one cycle, compare current outputs to the model, then advance the model
    task automatic cycle(input string tag, input logic v, input logic [1:0] m,
                         input logic [31:0] pc, input logic [1:0] deq, input logic fl);
        logic [31:0] i0, i1;
        int          d;
        bit          acc;
        i0 = $urandom;
        i1 = $urandom;
        in_valid_i = v;
        in_mask_i  = m;
        in_pc_i    = pc;
        in_data_i  = {i0, i1};
        deq_cnt_i  = deq;
        flush_i    = fl;
        check_outputs(tag);
        if (fl) begin
            sb.delete();
        end else begin
            acc = v && ((DEPTH - sb.size()) >= LANES);
            d   = (int'(deq) > sb.size()) ? sb.size() : int'(deq);
            repeat (d) void'(sb.pop_front());
            if (acc && m[1]) sb.push_back('{inst: i0, pc: pc});
            if (acc && m[0]) sb.push_back('{inst: i1, pc: pc + 32'd4});
        end
        @(posedge clock_i);
        #1;
        in_valid_i = 1'b0;
        deq_cnt_i  = 2'd0;
        flush_i    = 1'b0;
    endtask

    initial begin
        reset_n_i  = 1'b0;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        in_mask_i  = '0;
        in_pc_i    = '0;
        in_data_i  = '0;
        deq_cnt_i  = '0;

        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'($urandom);
            in_mask_i  = 2'($urandom);
            in_pc_i    = $urandom;
            in_data_i  = {$urandom, $urandom};
            deq_cnt_i  = 2'($urandom_range(0, 2));
            flush_i    = 1'($urandom);
            @(posedge clock_i);
            #1;
            check("rst.count", 64'(count_o), 64'd0);
            check("rst.valid", 64'(out_valid_o), 64'd0);
            check("rst.ready", 64'(in_ready_o), 64'd1);
            check("rst.inst",  64'(out_inst_o), 64'd0);
            check("rst.pc",    64'(out_pc_o), 64'd0);
        end
        in_valid_i = 1'b0;
        deq_cnt_i  = '0;
        flush_i    = 1'b0;
        reset_n_i  = 1'b1;
        @(posedge clock_i);
        #1;
        check_outputs("post_rst");

        for (int g = 0; g < 4; g++) cycle("fill", 1'b1, 2'b11, 32'h100 + 32'(8 * g), 2'd0, 1'b0);
        check("full.count", 64'(count_o), 64'd8);
        check("full.ready", 64'(in_ready_o), 64'd0);
        check("full.pc0",   64'(out_pc_o[63:32]), 64'h100);
        check("full.pc1",   64'(out_pc_o[31:0]), 64'h104);
        cycle("overfill", 1'b1, 2'b11, 32'h120, 2'd0, 1'b0);
        check("overfill.count", 64'(count_o), 64'd8);

        for (int i = 0; i < 3; i++) cycle("partial", 1'b0, 2'b00, 32'h0, 2'd1, 1'b0);
        check("partial.count", 64'(count_o), 64'd5);
        check("partial.pc0",   64'(out_pc_o[63:32]), 64'h10C);
        cycle("enq_deq", 1'b1, 2'b11, 32'h200, 2'd2, 1'b0);
        check("enq_deq.count", 64'(count_o), 64'd5);
        while (sb.size() > 0) cycle("drain", 1'b0, 2'b00, 32'h0, 2'd2, 1'b0);
        check_outputs("drained");

        cycle("misalign", 1'b1, 2'b01, 32'h300, 2'd0, 1'b0);
        check("misalign.valid", 64'(out_valid_o), 64'h1);
        check("misalign.pc0",   64'(out_pc_o[63:32]), 64'h304);
        cycle("misalign_deq", 1'b0, 2'b00, 32'h0, 2'd1, 1'b0);

        for (int g = 0; g < 3; g++) cycle("pre_flush", 1'b1, 2'b11, 32'h400 + 32'(8 * g), 2'd0, 1'b0);
        check("pre_flush.count", 64'(count_o), 64'd6);
        cycle("flush", 1'b1, 2'b11, 32'h500, 2'd2, 1'b1);
        check("flush.count", 64'(count_o), 64'd0);
        check("flush.valid", 64'(out_valid_o), 64'd0);
        check("flush.ready", 64'(in_ready_o), 64'd1);

        cycle("clamp_fill", 1'b1, 2'b10, 32'h600, 2'd0, 1'b0);
        check("clamp_fill.count", 64'(count_o), 64'd1);
        cycle("clamp", 1'b0, 2'b00, 32'h0, 2'd2, 1'b0);
        check("clamp.count", 64'(count_o), 64'd0);
        cycle("clamp_after", 1'b1, 2'b11, 32'h700, 2'd0, 1'b0);
        check("clamp_after.pc0", 64'(out_pc_o[63:32]), 64'h700);
        check("clamp_after.pc1", 64'(out_pc_o[31:0]), 64'h704);

        for (int i = 0; i < 80; i++) begin
            cycle("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom),
                  32'h1000 + 32'(16 * i), 2'($urandom_range(0, 2)),
                  1'($urandom_range(0, 15) == 0));
        end
        check_outputs("rand_end");

        cycle("pre_arst", 1'b1, 2'b11, 32'h800, 2'd0, 1'b0);
        cycle("pre_arst", 1'b1, 2'b11, 32'h808, 2'd0, 1'b0);
        #2;
        reset_n_i = 1'b0;
        #1;
        sb.delete();
        check("arst.count", 64'(count_o), 64'd0);
        check("arst.valid", 64'(out_valid_o), 64'd0);
        check("arst.ready", 64'(in_ready_o), 64'd1);
        check("arst.pc",    64'(out_pc_o), 64'd0);
        @(posedge clock_i);
        #1;
        reset_n_i = 1'b1;
        @(posedge clock_i);
        #1;
        check_outputs("post_arst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
